// File: rtl/order_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : order_tx_arbiter_pkg
// Description : Shared order-field widths and arbiter FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package order_tx_arbiter_pkg;

    localparam int INST_ID_W = 16;
    localparam int PRICE_W   = 32;
    localparam int SIZE_W    = 16;
    localparam int TS_W      = 48;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_THROTTLED = 2'd1,
        ST_HALTED    = 2'd2
    } arb_state_t;

endpackage : order_tx_arbiter_pkg
`default_nettype wire

// File: rtl/order_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : order_rr_arbiter
// Description : Combinational round-robin pick starting after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module order_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        w_found      = 1'b0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found              = 1'b1;
                grant_onehot[w_cand] = 1'b1;
                grant_idx            = w_cand;
            end
        end
    end

endmodule : order_rr_arbiter
`default_nettype wire

// File: rtl/order_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : order_tx_arbiter
// Description : Token-bucket rate-limited round-robin order issue to encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module order_tx_arbiter
    import order_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TOKENS_MAX    = 8,
    parameter int REFILL_PERIOD = 16,
    localparam int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TOK_W        = $clog2(TOKENS_MAX + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*INST_ID_W-1:0]  req_inst_id,
    input  logic [NUM_REQ*PRICE_W-1:0]    req_price,
    input  logic [NUM_REQ*SIZE_W-1:0]     req_qty,
    input  logic [NUM_REQ-1:0]            req_side,
    input  logic [NUM_REQ*TS_W-1:0]       req_ts,
    output logic                          enc_valid,
    output logic [INST_ID_W-1:0]          enc_inst_id,
    output logic [PRICE_W-1:0]            enc_price,
    output logic [SIZE_W-1:0]             enc_qty,
    output logic                          enc_side,
    output logic [TS_W-1:0]               enc_ts_in,
    output logic [SRC_W-1:0]              enc_src,
    input  logic                          kill,
    input  logic                          arm,
    output logic [1:0]                    state,
    output logic [TOK_W-1:0]              tokens,
    output logic [31:0]                   sent_cnt,
    output logic [31:0]                   throttle_cnt
);

    localparam int CNT_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam logic [TOK_W-1:0] c_TOK_MAX = TOK_W'(TOKENS_MAX);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(REFILL_PERIOD - 1);

    arb_state_t       r_state, w_state_next;
    logic [TOK_W-1:0] r_tokens, w_tokens_next;
    logic [CNT_W-1:0] r_refill_cnt;
    logic [SRC_W-1:0] r_last_grant;
    logic [31:0]      r_sent_cnt, r_throttle_cnt;

    logic [NUM_REQ-1:0] w_grant_onehot;
    logic [SRC_W-1:0]   w_grant_idx;
    logic               w_can_grant, w_accept, w_refill;

    order_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr (
        .req          (req_valid),
        .last_grant   (r_last_grant),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx)
    );

    assign w_can_grant = (r_state == ST_RUN) && (r_tokens != '0) && !kill && !rst;
    assign req_ready   = w_can_grant ? w_grant_onehot : '0;
    assign w_accept    = |(req_valid & req_ready);
    assign w_refill    = (r_refill_cnt == c_CNT_MAX);

    // A simultaneous accept and refill cancel out, which also keeps a full bucket full.
    always_comb begin
        w_tokens_next = r_tokens;
        if (w_accept && !w_refill)
            w_tokens_next = r_tokens - 1'b1;
        else if (w_refill && !w_accept && (r_tokens != c_TOK_MAX))
            w_tokens_next = r_tokens + 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        if (kill) begin
            w_state_next = ST_HALTED;
        end else begin
            case (r_state)
                ST_RUN:       if (w_tokens_next == '0) w_state_next = ST_THROTTLED;
                ST_THROTTLED: if (w_tokens_next != '0) w_state_next = ST_RUN;
                ST_HALTED:    if (arm) w_state_next = (r_tokens == '0) ? ST_THROTTLED : ST_RUN;
                default:      w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tokens       <= c_TOK_MAX;
            r_refill_cnt   <= '0;
            r_last_grant   <= SRC_W'(NUM_REQ - 1);
            r_sent_cnt     <= '0;
            r_throttle_cnt <= '0;
            enc_valid      <= 1'b0;
            enc_inst_id    <= '0;
            enc_price      <= '0;
            enc_qty        <= '0;
            enc_side       <= 1'b0;
            enc_ts_in      <= '0;
            enc_src        <= '0;
        end else begin
            r_tokens     <= w_tokens_next;
            r_refill_cnt <= w_refill ? '0 : r_refill_cnt + 1'b1;
            enc_valid    <= w_accept;
            if (w_accept) begin
                r_last_grant <= w_grant_idx;
                r_sent_cnt   <= r_sent_cnt + 32'd1;
                enc_inst_id  <= req_inst_id[w_grant_idx*INST_ID_W +: INST_ID_W];
                enc_price    <= req_price[w_grant_idx*PRICE_W +: PRICE_W];
                enc_qty      <= req_qty[w_grant_idx*SIZE_W +: SIZE_W];
                enc_side     <= req_side[w_grant_idx];
                enc_ts_in    <= req_ts[w_grant_idx*TS_W +: TS_W];
                enc_src      <= w_grant_idx;
            end
            if ((|req_valid) && (r_tokens == '0) && (r_state != ST_HALTED) &&
                (r_throttle_cnt != 32'hFFFF_FFFF))
                r_throttle_cnt <= r_throttle_cnt + 32'd1;
        end
    end

    assign state        = r_state;
    assign tokens       = r_tokens;
    assign sent_cnt     = r_sent_cnt;
    assign throttle_cnt = r_throttle_cnt;

endmodule : order_tx_arbiter
`default_nettype wire

// File: tb/tb_order_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_order_tx_arbiter
// Description : Directed self-checking bench for order_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_order_tx_arbiter;
    import order_tx_arbiter_pkg::*;

    localparam int NR = 4;

    logic                     clk = 1'b0;
    logic                     rst, kill, arm;
    logic [NR-1:0]            req_valid, req_ready, req_side;
    logic [NR*INST_ID_W-1:0]  req_inst_id;
    logic [NR*PRICE_W-1:0]    req_price;
    logic [NR*SIZE_W-1:0]     req_qty;
    logic [NR*TS_W-1:0]       req_ts;
    logic                     enc_valid, enc_side;
    logic [INST_ID_W-1:0]     enc_inst_id;
    logic [PRICE_W-1:0]       enc_price;
    logic [SIZE_W-1:0]        enc_qty;
    logic [TS_W-1:0]          enc_ts_in;
    logic [1:0]               enc_src, state;
    logic [3:0]               tokens;
    logic [31:0]              sent_cnt, throttle_cnt;

    int n_checks = 0;
    int n_errors = 0;

    order_tx_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_inst_id(req_inst_id), .req_price(req_price), .req_qty(req_qty),
        .req_side(req_side), .req_ts(req_ts), .enc_valid(enc_valid),
        .enc_inst_id(enc_inst_id), .enc_price(enc_price), .enc_qty(enc_qty),
        .enc_side(enc_side), .enc_ts_in(enc_ts_in), .enc_src(enc_src),
        .kill(kill), .arm(arm), .state(state), .tokens(tokens),
        .sent_cnt(sent_cnt), .throttle_cnt(throttle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 after reset release.
    task automatic do_reset();
        rst = 1'b1; req_valid = '0; kill = 1'b0; arm = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_inst_id[i*INST_ID_W +: INST_ID_W] = 16'h0010 + 16'(i);
            req_price[i*PRICE_W +: PRICE_W]       = 32'h0000_0100 + 32'(i);
            req_qty[i*SIZE_W +: SIZE_W]           = 16'h0020 + 16'(i);
            req_ts[i*TS_W +: TS_W]                = 48'h0000_0000_0300 + 48'(i);
            req_side[i]                           = 1'b0;
        end
        req_inst_id[1*INST_ID_W +: INST_ID_W] = 16'h0007;
        req_price[1*PRICE_W +: PRICE_W]       = 32'h0000_1234;
        req_qty[1*SIZE_W +: SIZE_W]           = 16'h0064;
        req_ts[1*TS_W +: TS_W]                = 48'h0000_0000_0ABC;
        req_side[1]                           = 1'b1;

        // Reset values, and ready held low while rst is asserted
        rst = 1'b1; kill = 1'b0; arm = 1'b0; req_valid = 4'hF;
        #1;
        chk("ready_in_rst", req_ready, 0);
        do_reset();
        #1;
        chk("rst_enc_valid", enc_valid, 0);
        chk("rst_tokens", tokens, 8);
        chk("rst_state", state, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_throttle", throttle_cnt, 0);
        chk("rst_enc_src", enc_src, 0);
        chk("rst_enc_price", enc_price, 0);

        // Round-robin over all four requesters with a full bucket
        req_valid = 4'hF;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_ready_c%0d", i), req_ready, 64'(1 << (i % 4)));
            if (i >= 1) begin
                chk($sformatf("rr_encv_c%0d", i), enc_valid, 1);
                chk($sformatf("rr_src_c%0d", i), enc_src, 64'((i - 1) % 4));
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_encv_last", enc_valid, 1);
        chk("rr_src_last", enc_src, 1);
        chk("rr_tokens", tokens, 2);
        tick();
        chk("rr_encv_idle", enc_valid, 0);
        chk("rr_sent", sent_cnt, 6);
        chk("rr_price_hold", enc_price, 32'h0000_1234);

        // Accept coinciding with the refill wrap at tokens=3
        do_reset();
        req_valid = 4'b0100;
        tick(5);
        chk("co_tokens_pre", tokens, 3);
        req_valid = '0;
        tick(10);
        req_valid = 4'b0100;
        #1;
        chk("co_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("co_tokens_post", tokens, 3);
        chk("co_sent", sent_cnt, 6);

        // Bucket drain, throttle, single refill token
        do_reset();
        req_valid = 4'b0100;
        tick(7);
        chk("th_ready_c7", req_ready, 4'b0100);
        chk("th_tokens_c7", tokens, 1);
        tick();
        chk("th_state_c8", state, 1);
        chk("th_ready_c8", req_ready, 0);
        chk("th_tokens_c8", tokens, 0);
        chk("th_cnt_c8", throttle_cnt, 0);
        tick(2);
        chk("th_cnt_c10", throttle_cnt, 2);
        tick(6);
        chk("th_state_c16", state, 0);
        chk("th_tokens_c16", tokens, 1);
        chk("th_ready_c16", req_ready, 4'b0100);
        chk("th_cnt_c16", throttle_cnt, 8);
        tick();
        chk("th_state_c17", state, 1);
        chk("th_ready_c17", req_ready, 0);
        chk("th_sent_c17", sent_cnt, 9);
        chk("th_encv_c17", enc_valid, 1);
        chk("th_src_c17", enc_src, 2);
        chk("th_cnt_c17", throttle_cnt, 8);
        req_valid = '0;

        // Kill mid-burst, then re-arm
        do_reset();
        req_valid = 4'hF;
        tick(2);
        kill = 1'b1;
        #1;
        chk("kill_ready", req_ready, 0);
        chk("kill_encv", enc_valid, 1);
        chk("kill_src", enc_src, 1);
        tick();
        kill = 1'b0;
        #1;
        chk("halt_state", state, 2);
        chk("halt_encv", enc_valid, 0);
        chk("halt_sent", sent_cnt, 2);
        chk("halt_tokens", tokens, 6);
        chk("halt_ready", req_ready, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        #1;
        chk("arm_state", state, 0);
        chk("arm_ready", req_ready, 4'b0100);
        req_valid = '0;

        // Exact field transfer from requester 1
        do_reset();
        req_valid = 4'b0010;
        #1;
        chk("fld_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("fld_encv", enc_valid, 1);
        chk("fld_src", enc_src, 1);
        chk("fld_inst", enc_inst_id, 16'h0007);
        chk("fld_price", enc_price, 32'h0000_1234);
        chk("fld_qty", enc_qty, 16'h0064);
        chk("fld_side", enc_side, 1);
        chk("fld_ts", enc_ts_in, 48'h0000_0000_0ABC);

        // Reset in the cycle after an accept
        do_reset();
        req_valid = 4'b0001;
        tick();
        rst = 1'b1;
        #1;
        chk("rst2_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        chk("rst2_encv", enc_valid, 0);
        chk("rst2_tokens", tokens, 8);
        chk("rst2_sent", sent_cnt, 0);
        chk("rst2_src", enc_src, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_order_tx_arbiter
`default_nettype wire

// File: doc/order_tx_arbiter.md
ORDER_TX_ARBITER -- requirements
Module: order_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of strategy requesters.
REQ-002 The block SHALL have parameter TOKENS_MAX, default 8, the token-bucket depth in orders.
REQ-003 The block SHALL have parameter REFILL_PERIOD, default 16, the cycles per token added.
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, the per-requester order-valid signals.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ, the per-requester accept signals, at most one bit high.
REQ-008 The block SHALL have ports req_inst_id, req_price, req_qty, req_side and req_ts, inputs, NUM_REQ times INST_ID_W, PRICE_W, SIZE_W, 1 and TS_W, the flattened order fields with requester i at slice i.
REQ-009 The block SHALL have ports enc_valid, enc_inst_id, enc_price, enc_qty, enc_side and enc_ts_in, outputs of width 1, INST_ID_W, PRICE_W, SIZE_W, 1 and TS_W, driving the order encoder.
REQ-010 The block SHALL have port enc_src, output, clog2(NUM_REQ), the index of the issuing requester.
REQ-011 The block SHALL have ports kill, input, 1, and arm, input, 1, the risk halt and re-enable pulses.
REQ-012 The block SHALL have ports state, output, 2; tokens, output, clog2(TOKENS_MAX+1); sent_cnt, output, 32; and throttle_cnt, output, 32.

Function
REQ-013 Handshake: an order from requester i SHALL be accepted exactly when req_valid[i] and req_ready[i] are both high on a rising edge.
REQ-014 req_ready SHALL be combinational, SHALL be one-hot or zero, and SHALL be nonzero only when state is RUN, tokens > 0, kill = 0 and at least one req_valid is high.
REQ-015 Grant selection SHALL be round-robin: the search SHALL start at (last_grant+1) mod NUM_REQ, last_grant SHALL reset to NUM_REQ-1, and last_grant SHALL update only on an accept.
REQ-016 On an accept, the enc_* outputs SHALL be registered with the granted fields and enc_valid SHALL be high the next cycle only, giving 1-cycle latency and at most one issue per cycle.
REQ-017 When enc_valid is low, the enc_* data outputs SHALL hold their last values.
REQ-018 The refill counter SHALL count 0 to REFILL_PERIOD-1 and wrap; on wrap, tokens SHALL increment, saturating at TOKENS_MAX.
REQ-019 An accept SHALL decrement tokens; when an accept and a refill occur in the same cycle, tokens SHALL be unchanged; when tokens = TOKENS_MAX, an accept and a refill in the same cycle SHALL leave tokens at TOKENS_MAX.
REQ-020 The FSM SHALL have states RUN=0, THROTTLED=1 and HALTED=2.
REQ-021 The FSM SHALL go from RUN to THROTTLED when the next tokens value is 0.
REQ-022 The FSM SHALL go from THROTTLED to RUN when the next tokens value is greater than 0.
REQ-023 The FSM SHALL go from any state to HALTED when kill = 1, and kill SHALL take priority over all other transitions.
REQ-024 The FSM SHALL go from HALTED to RUN when arm = 1 and kill = 0, or to THROTTLED if tokens = 0.
REQ-025 kill high SHALL block any accept in the same cycle, and refill SHALL continue while HALTED.
REQ-026 sent_cnt SHALL increment on each accept and wrap modulo 2^32.
REQ-027 throttle_cnt SHALL increment, saturating at 2^32-1, in each cycle where any req_valid is high and tokens = 0 while not HALTED.

Reset
REQ-028 On rst, the block SHALL set enc_valid=0, all enc_* data outputs=0, enc_src=0, state=RUN, tokens=TOKENS_MAX, the refill counter=0, last_grant=NUM_REQ-1, sent_cnt=0 and throttle_cnt=0.
REQ-029 rst asserted while an order is pending issue SHALL drop that order with no enc_valid pulse, and req_ready SHALL be 0 during rst.

Structure
REQ-030 INST_ID_W, PRICE_W, SIZE_W, TS_W and the FSM state encodings SHALL live in the shared defs package.
REQ-031 Round-robin selection SHALL be a sub-module, order_rr_arbiter, taking inputs req and last_grant and producing outputs grant_onehot and grant_idx.

Verification
REQ-032 When req_valid=4'b1111 is held with tokens full, the bench SHALL see grants ordered 0,1,2,3,0,... with one enc_valid per cycle and enc_src matching.
REQ-033 When req_valid[2]=1 is held with no refill in window, the bench SHALL see 8 accepts, then state=THROTTLED, req_ready=0 and throttle_cnt counting; after 16 cycles, 1 accept and then THROTTLED again.
REQ-034 When kill is pulsed mid-burst, the bench SHALL see no accept in the kill cycle, state=HALTED, and the pending enc_valid still emitted once; arm then SHALL return state to RUN.
REQ-035 When an accept coincides with a refill wrap at tokens=3, the bench SHALL see tokens remain 3.
REQ-036 When requester 1 presents price=0x00001234, qty=0x0064, inst_id=0x0007, side=1 and ts=0x000000000ABC, the bench SHALL see these exact values on enc_* one cycle later.
REQ-037 When rst is asserted in the cycle after an accept, the bench SHALL see enc_valid=0, tokens=8 and sent_cnt=0.
